// File: rtl/sum_cla_pkg.sv
// Shared definitions for the multi-cycle CLA adder: nibble width and FSM state encoding.
package sum_cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sum_cla_multiciclo_if.sv
// Operand and result handshake bundle between a producer/consumer and sum_cla_multiciclo.
interface sum_cla_multiciclo_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/sum_cla_multiciclo_cla.sv
// sumCla: purely combinational 4-bit carry-lookahead adder stage.
module sumCla
    import sum_cla_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    output logic [NIB_W-1:0] sum_o,
    output logic             cout_o
);
    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Every carry is a flat sum of products of p/g/cin, so no ripple path exists.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_o  = p ^ c[NIB_W-1:0];
    assign cout_o = c[NIB_W];
endmodule

// File: rtl/sum_cla_multiciclo.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single sumCla, carry chained
// through a register, with valid/ready handshakes on operands and result.
module sum_cla_multiciclo
    import sum_cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    sum_cla_multiciclo_if.slave bus
);
    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("sum_cla_multiciclo: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             accept;
    logic             cla_cin;
    logic [NIB_W-1:0] cla_sum;
    logic             cla_cout;

    assign bus.in_ready = (state_q == ST_IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign cla_cin      = (idx_q == '0) ? cin_q : carry_q;

    // Operands shift right each RUN cycle so the active nibble always sits in bits [3:0].
    sumCla u_cla (
        .a_i    (a_q[NIB_W-1:0]),
        .b_i    (b_q[NIB_W-1:0]),
        .cin_i  (cla_cin),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

    // NOTE: operand registers carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            cin_q <= bus.cin;
        end else if (state_q == ST_RUN) begin
            a_q <= a_q >> NIB_W;
            b_q <= b_q >> NIB_W;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_q[idx_q*NIB_W +: NIB_W] <= cla_sum;
                    carry_q                     <= cla_cout;
                    idx_q                       <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        cout_q      <= cla_cout;
                        ovf_q       <= (a_q[NIB_W-1] == b_q[NIB_W-1])
                                    && (cla_sum[NIB_W-1] != a_q[NIB_W-1]);
                    end
                end
                ST_DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_sum_cla_multiciclo.sv
// Self-checking bench for sum_cla_multiciclo (WIDTH=16): directed cases plus random operands
// against an integer-arithmetic reference model.
module tb_sum_cla_multiciclo;
    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sum_cla_multiciclo_if #(.WIDTH(WIDTH)) bus ();

    sum_cla_multiciclo #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         output logic [WIDTH-1:0] sum, output logic cout, output logic ovf);
        longint u;
        longint s;
        u    = longint'(a) + longint'(b) + longint'(cin);
        s    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        sum  = u[WIDTH-1:0];
        cout = (u >= (64'd1 << WIDTH));
        ovf  = (s > ((64'sd1 <<< (WIDTH-1)) - 1)) || (s < -(64'sd1 <<< (WIDTH-1)));
    endtask

    // Waits (bounded) for in_ready, presents operands for the accept edge; returns at the following negedge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Counts edges after accept until out_valid, then compares the result with the model.
    task automatic wait_result(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH-1:0] e_sum;
        logic             e_cout;
        logic             e_ovf;
        int               k;
        model(a, b, cin, e_sum, e_cout, e_ovf);
        k = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end while (!bus.out_valid && k < 20);
        check({tag, "_latency"}, 32'(k), 32'(NIBBLES));
        check({tag, "_sum"}, 32'(bus.sum), 32'(e_sum));
        check({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(e_ovf));
    endtask

    task automatic take_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH-1:0] held;
        int               seen;

        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Directed cases
        send(16'h1234, 16'h4321, 1'b0);
        wait_result("d1", 16'h1234, 16'h4321, 1'b0);
        check("d1_sum_const", 32'(bus.sum), 32'h5555);
        take_result("d1");

        send(16'hFFFF, 16'h0001, 1'b0);
        wait_result("d2", 16'hFFFF, 16'h0001, 1'b0);
        check("d2_cout_const", 32'(bus.cout), 32'd1);
        take_result("d2");

        send(16'h7FFF, 16'h0000, 1'b1);
        wait_result("d3", 16'h7FFF, 16'h0000, 1'b1);
        check("d3_ovf_const", 32'(bus.ovf), 32'd1);
        take_result("d3");

        // Backpressure with a new operand pending
        send(16'h8000, 16'h8000, 1'b0);
        wait_result("bp", 16'h8000, 16'h8000, 1'b0);
        held         = bus.sum;
        bus.a        = 16'h0F0F;
        bus.b        = 16'h00F1;
        bus.cin      = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_sum_stable", 32'(bus.sum), 32'(held));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release_ovalid", 32'(bus.out_valid), 32'd0);
        check("bp_release_iready", 32'(bus.in_ready), 32'd1);
        check("bp_sum_held", 32'(bus.sum), 32'(held));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_result("bp_next", 16'h0F0F, 16'h00F1, 1'b1);
        take_result("bp_next");

        // Reset in the second RUN cycle aborts the operation
        send(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        send(16'h0001, 16'h0002, 1'b0);
        wait_result("after_abort", 16'h0001, 16'h0002, 1'b0);
        check("after_abort_sum_const", 32'(bus.sum), 32'h0003);
        take_result("after_abort");

        // Random operands with random consumer delay
        for (int n = 0; n < 25; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(1, 0));
            send(ra, rb, rc);
            wait_result("rnd", ra, rb, rc);
            held = bus.sum;
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("rnd_hold", 32'(bus.sum), 32'(held));
            take_result("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
